route_fifo_param: RTL and testbench
===================================

Name: route_fifo_param

Overview:
- Parametrised successor to the fixed 4-bit FIFO/MUX/DEMUX datapath in the Zigbee TOP.
- One synchronous FIFO, DEPTH x DATA_W, with N_IN selectable write lanes (input mux) and N_OUT selectable read lanes (output demux).
- Adds occupancy count, almost-full threshold, flush, and sticky overflow/underflow flags.
- Sits between the Zigbee symbol source and the per-channel consumers.

Parameters:
- DATA_W, 4, data word width in bits (>=1).
- DEPTH, 16, FIFO entries; power of two, >=2.
- N_IN, 2, number of write lanes (>=2).
- N_OUT, 2, number of read lanes (>=2).
- AF_LEVEL, 12, count at or above which outAlmostFull asserts (1..DEPTH).

Ports:
- inClock  in  1  sole clock; all logic on its rising edge.
- inReset  in  1  synchronous reset, active-high.
- inData  in  N_IN*DATA_W  packed write lanes; lane i = bits [i*DATA_W +: DATA_W].
- inSelIn  in  $clog2(N_IN)  write lane select.
- inWriteEnable  in  1  write request.
- inReadEnable  in  1  read request.
- inSelOut  in  $clog2(N_OUT)  read lane select.
- inFlush  in  1  synchronous empty of FIFO contents.
- inClearFlags  in  1  clears the sticky flags.
- outData  out  N_OUT*DATA_W  packed read lanes.
- outValid  out  N_OUT  one-hot pulse marking the lane that carries read data.
- outEmpty  out  1  count==0.
- outFull  out  1  count==DEPTH.
- outAlmostFull  out  1  count>=AF_LEVEL.
- outCount  out  $clog2(DEPTH)+1  current occupancy.
- outOverflow  out  1  sticky: a write was rejected.
- outUnderflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset, sampled at the edge while inReset=1: pointers=0, count=0, outData=0, outValid=0, outOverflow=0, outUnderflow=0. This gives outEmpty=1, outFull=0, outAlmostFull=0.
- Reset has priority over every other input. A reset mid-operation discards all stored data.
- Write accepted = inWriteEnable & (!full | rdAccepted). Stores lane inSelIn of inData at wrPtr; wrPtr increments and wraps modulo DEPTH.
- Read accepted = inReadEnable & !empty. Occupancy is taken from the pre-edge state, so a same-cycle write into an empty FIFO is not readable that cycle.
- Read latency is 1 cycle. The head word appears on lane inSelOut (sampled at the accepting edge) and outValid[inSelOut]=1 for exactly one cycle.
- All other outData lanes drive 0, and all lanes drive 0 whenever outValid=0.
- Full with simultaneous read and write: both are accepted and count is unchanged.
- Empty with simultaneous read and write: write accepted, read rejected, outUnderflow set.
- Rejected write (full, no read): data dropped, outOverflow set.
- Rejected read (empty): outValid stays 0, outUnderflow set.
- Sticky flags clear only on inReset or inClearFlags.
- If inClearFlags coincides with a new rejection, the set wins.
- inFlush: pointers and count go to 0 and outValid goes to 0 at the next edge. Reads and writes in the same cycle are ignored and do not set flags. Sticky flags are unaffected.
- Out-of-range selects (>= N_IN or >= N_OUT for non-power-of-two counts) are treated as a rejected request: no storage, no pointer change, flag set.
- Status outputs are combinational from the registered count.

Decomposition:
- Package route_fifo_pkg holds:
  - function clog2_min1, returning >=1 so select width stays nonzero;
  - localparam helpers PTR_W and CNT_W;
  - typedef enum {OP_IDLE, OP_WR, OP_RD, OP_RW} fifo_op_e, used for the count-update case.
- Sub-module sync_fifo_core holds storage, pointers and count, and emits accepted strobes.
- The top handles lane mux/demux, output registers and sticky flags.

Test Plan:
- Reset, then write lane 1 values 0x3,0x5,0x9 (N_IN=2), then read with inSelOut=1 three times -> outData lane 1 = 0x3,0x5,0x9 one cycle after each read; outValid=2'b10; lane 0 stays 0; outCount 3->0.
- Write 16 words with no reads -> outFull=1, outCount=16, outAlmostFull asserted from count 12. A 17th write gives outOverflow=1 and contents unchanged; read 16 -> original order.
- Full, then read and write together -> outCount stays 16, written word emerges last, no overflow.
- Empty, then read and write together -> outUnderflow=1, outCount=1, no outValid. inClearFlags -> outUnderflow=0.
- 8 words stored, then inFlush with simultaneous write -> outCount=0, outEmpty=1, next read sets underflow.
- Reset asserted mid-burst (5 stored, read pending) -> next cycle outValid=0, outData=0, outCount=0, flags=0.

Source files
------------

// File: rtl/route_fifo_pkg.sv
// Shared helpers for the routed FIFO: width functions, default widths and the
// count-update opcode.
package route_fifo_pkg;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int ptr_w_f(input int depth);
    return clog2_min1(depth);
  endfunction

  function automatic int cnt_w_f(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_DEPTH = 16;
  localparam int PTR_W     = ptr_w_f(DEF_DEPTH);
  localparam int CNT_W     = cnt_w_f(DEF_DEPTH);

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/sync_fifo_core.sv
// Storage, pointers and occupancy count of the routed FIFO; reports which
// requests were accepted this cycle.
module sync_fifo_core
  import route_fifo_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       wr_req_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       rd_req_i,
  output logic                       wr_acc_o,
  output logic                       rd_acc_o,
  output logic [DATA_W-1:0]          head_o,
  output logic [cnt_w_f(DEPTH)-1:0]  count_o
);

  localparam int PW = ptr_w_f(DEPTH);
  localparam int CW = cnt_w_f(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              empty, full;
  fifo_op_e          op;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Read admission uses pre-edge occupancy; a full FIFO accepts a write only
  // when a read frees a slot in the same cycle.
  assign rd_acc_o = rd_req_i & ~empty & ~flush_i;
  assign wr_acc_o = wr_req_i & (~full | rd_acc_o) & ~flush_i;
  assign op       = fifo_op_e'({rd_acc_o, wr_acc_o});

  always_comb begin
    count_d = count_q;
    case (op)
      OP_WR:   count_d = count_q + CW'(1);
      OP_RD:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_acc_o) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_acc_o) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc_o) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/route_fifo_param.sv
// Routed FIFO top: write-lane mux, registered read-lane demux, status decode
// and sticky overflow/underflow flags around sync_fifo_core.
module route_fifo_param
  import route_fifo_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int DEPTH    = 16,
  parameter int N_IN     = 2,
  parameter int N_OUT    = 2,
  parameter int AF_LEVEL = 12
) (
  input  logic                          inClock,
  input  logic                          inReset,
  input  logic [N_IN*DATA_W-1:0]        inData,
  input  logic [clog2_min1(N_IN)-1:0]   inSelIn,
  input  logic                          inWriteEnable,
  input  logic                          inReadEnable,
  input  logic [clog2_min1(N_OUT)-1:0]  inSelOut,
  input  logic                          inFlush,
  input  logic                          inClearFlags,
  output logic [N_OUT*DATA_W-1:0]       outData,
  output logic [N_OUT-1:0]              outValid,
  output logic                          outEmpty,
  output logic                          outFull,
  output logic                          outAlmostFull,
  output logic [cnt_w_f(DEPTH)-1:0]     outCount,
  output logic                          outOverflow,
  output logic                          outUnderflow
);

  localparam int SIW = clog2_min1(N_IN);
  localparam int SOW = clog2_min1(N_OUT);
  localparam int CW  = cnt_w_f(DEPTH);

  logic                    sel_in_ok, sel_out_ok;
  logic [DATA_W-1:0]       wr_word, head;
  logic                    wr_acc, rd_acc;
  logic [CW-1:0]           count;
  logic [N_OUT*DATA_W-1:0] data_q, data_d;
  logic [N_OUT-1:0]        valid_q, valid_d;
  logic                    ovf_q, ovf_d, unf_q, unf_d;

  // Selects beyond the lane count (non-power-of-two configurations) are
  // withheld from the core so they surface as rejected requests.
  assign sel_in_ok  = (32'(inSelIn) < N_IN);
  assign sel_out_ok = (32'(inSelOut) < N_OUT);

  always_comb begin
    wr_word = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (inSelIn == SIW'(i)) wr_word = inData[i*DATA_W +: DATA_W];
    end
  end

  sync_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk_i     (inClock),
    .rst_i     (inReset),
    .flush_i   (inFlush),
    .wr_req_i  (inWriteEnable & sel_in_ok),
    .wr_data_i (wr_word),
    .rd_req_i  (inReadEnable & sel_out_ok),
    .wr_acc_o  (wr_acc),
    .rd_acc_o  (rd_acc),
    .head_o    (head),
    .count_o   (count)
  );

  always_comb begin
    data_d  = '0;
    valid_d = '0;
    if (rd_acc) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (inSelOut == SOW'(j)) begin
          data_d[j*DATA_W +: DATA_W] = head;
          valid_d[j]                 = 1'b1;
        end
      end
    end
  end

  // A new rejection beats a simultaneous clear; flush neither sets nor clears.
  assign ovf_d = (~inFlush & inWriteEnable & ~wr_acc) | (ovf_q & ~inClearFlags);
  assign unf_d = (~inFlush & inReadEnable & ~rd_acc) | (unf_q & ~inClearFlags);

  always_ff @(posedge inClock) begin
    if (inReset) begin
      data_q  <= '0;
      valid_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign outData       = data_q;
  assign outValid      = valid_q;
  assign outOverflow   = ovf_q;
  assign outUnderflow  = unf_q;
  assign outCount      = count;
  assign outEmpty      = (count == '0);
  assign outFull       = (count == CW'(DEPTH));
  assign outAlmostFull = (count >= CW'(AF_LEVEL));

endmodule

// File: tb/tb_route_fifo_param.sv
// Directed bench for route_fifo_param: queue scoreboard of stored words,
// checked every cycle against count, read lanes, status and sticky flags.
module tb_route_fifo_param;

  localparam int DW    = 4;
  localparam int DEPTH = 16;
  localparam int NI    = 2;
  localparam int NO    = 2;
  localparam int AF    = 12;

  logic             inClock = 1'b0;
  logic             inReset, inWriteEnable, inReadEnable, inFlush, inClearFlags;
  logic [NI*DW-1:0] inData;
  logic [0:0]       inSelIn, inSelOut;
  logic [NO*DW-1:0] outData;
  logic [NO-1:0]    outValid;
  logic             outEmpty, outFull, outAlmostFull, outOverflow, outUnderflow;
  logic [4:0]       outCount;

  route_fifo_param #(
    .DATA_W(DW), .DEPTH(DEPTH), .N_IN(NI), .N_OUT(NO), .AF_LEVEL(AF)
  ) dut (
    .inClock       (inClock),
    .inReset       (inReset),
    .inData        (inData),
    .inSelIn       (inSelIn),
    .inWriteEnable (inWriteEnable),
    .inReadEnable  (inReadEnable),
    .inSelOut      (inSelOut),
    .inFlush       (inFlush),
    .inClearFlags  (inClearFlags),
    .outData       (outData),
    .outValid      (outValid),
    .outEmpty      (outEmpty),
    .outFull       (outFull),
    .outAlmostFull (outAlmostFull),
    .outCount      (outCount),
    .outOverflow   (outOverflow),
    .outUnderflow  (outUnderflow)
  );

  always #5 inClock = ~inClock;

  logic [DW-1:0] sb[$];
  bit            ovf_m, unf_m;
  int            errors = 0;
  int            checks = 0;
  int            stepno = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s@step%0d observed=%0h expected=%0h", tag, stepno, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare just after the edge.
  task automatic step(input bit rst, input bit we, input int lane, input logic [DW-1:0] val,
                      input bit re, input int osel, input bit fl, input bit clr);
    bit            rd_ok, wr_ok;
    logic [DW-1:0] rv;
    logic [NO-1:0] ev;
    logic [NO*DW-1:0] ed;
    stepno++;
    inReset       = rst;
    inWriteEnable = we;
    inSelIn       = lane[0];
    inData        = lane[0] ? {val, ~val} : {~val, val};
    inReadEnable  = re;
    inSelOut      = osel[0];
    inFlush       = fl;
    inClearFlags  = clr;
    ev = '0;
    ed = '0;
    if (rst) begin
      sb.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      if (clr) begin
        ovf_m = 1'b0;
        unf_m = 1'b0;
      end
      if (fl) begin
        sb.delete();
      end else begin
        rd_ok = re && (sb.size() > 0);
        wr_ok = we && ((sb.size() < DEPTH) || rd_ok);
        if (re && !rd_ok) unf_m = 1'b1;
        if (we && !wr_ok) ovf_m = 1'b1;
        if (rd_ok) begin
          rv = sb.pop_front();
          ev = NO'(1) << osel;
          ed = (NO*DW)'(rv) << (osel * DW);
        end
        if (wr_ok) sb.push_back(val);
      end
    end
    @(posedge inClock);
    #1;
    chk("count",     32'(outCount),      32'(sb.size()));
    chk("valid",     32'(outValid),      32'(ev));
    chk("data",      32'(outData),       32'(ed));
    chk("overflow",  32'(outOverflow),   32'(ovf_m));
    chk("underflow", 32'(outUnderflow),  32'(unf_m));
    chk("empty",     32'(outEmpty),      32'(sb.size() == 0));
    chk("full",      32'(outFull),       32'(sb.size() == DEPTH));
    chk("almost",    32'(outAlmostFull), 32'(sb.size() >= AF));
  endtask

  initial begin
    inReset = 1'b1; inWriteEnable = 1'b0; inReadEnable = 1'b0; inFlush = 1'b0;
    inClearFlags = 1'b0; inData = '0; inSelIn = '0; inSelOut = '0;

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // Lane-1 writes, lane-1 reads
    step(0, 1, 1, 4'h3, 0, 0, 0, 0);
    step(0, 1, 1, 4'h5, 0, 0, 0, 0);
    step(0, 1, 1, 4'h9, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1, 0, 0);

    // Fill to full, then one rejected write
    for (int i = 0; i < DEPTH; i++) step(0, 1, i % 2, 4'(i), 0, 0, 0, 0);
    step(0, 1, 0, 4'hE, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    // Full with read and write together, then drain in order on both lanes
    step(0, 1, 1, 4'hA, 1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1, i % 2, 0, 0);

    // Empty with read and write together
    step(0, 1, 0, 4'h6, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    // Clear coinciding with a new rejected read: the set wins
    step(0, 0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    // Flush with a simultaneous write, then a read on the emptied FIFO
    for (int i = 0; i < 8; i++) step(0, 1, i % 2, 4'(i + 3), 0, 0, 0, 0);
    step(0, 1, 0, 4'h7, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);

    // Reset in the middle of a burst with a read pending
    for (int i = 0; i < 5; i++) step(0, 1, 1, 4'(i + 8), 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
